// File: rtl/mem_fill_pkg.sv
// Shared encodings for the mem_fill RAM sequencer: pattern modes, FSM state codes
// and the RAM depth derivation.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        MODE_CONST   = 2'b00,
        MODE_CHECKER = 2'b01,
        MODE_INCR    = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FILL   = 3'd1;
    localparam state_t ST_VERIFY = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_FINISH = 3'd4;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_fill_if.sv
// Control and RAM-port bundle of mem_fill. The sequencer uses the slave view; the
// game controller / RAM side uses the master view.
interface mem_fill_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] fill_a;
    logic [DATA_W-1:0] fill_b;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              verify_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W:0]   err_count;

    modport slave (
        input  start, abort, mode, fill_a, fill_b, start_addr, end_addr, verify_en, rd_data,
        output ram_we, ram_addr, ram_data, rd_addr, busy, done, aborted, err_count
    );

    modport master (
        output start, abort, mode, fill_a, fill_b, start_addr, end_addr, verify_en, rd_data,
        input  ram_we, ram_addr, ram_data, rd_addr, busy, done, aborted, err_count
    );
endinterface

// File: rtl/mem_fill_pattern.sv
// Combinational fill-pattern generator: maps a cell address to the value the
// selected mode places there. Shared by the write path and the verify compare.
module mem_fill_pattern
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2,
    parameter int COL_W  = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] fill_a_i,
    input  logic [DATA_W-1:0] fill_b_i,
    output logic [DATA_W-1:0] data_o
);
    logic [ADDR_W-1:0] offs_s;
    logic [DATA_W-1:0] offs_trunc_s;

    assign offs_s       = addr_i - start_addr_i;
    assign offs_trunc_s = DATA_W'(offs_s);

    // Pattern select; the reserved mode falls back to a constant fill.
    always_comb begin
        data_o = fill_a_i;
        case (mode_i)
            MODE_CHECKER: begin
                if ((addr_i[0] ^ addr_i[COL_W]) == 1'b1) begin
                    data_o = fill_b_i;
                end else begin
                    data_o = fill_a_i;
                end
            end
            MODE_INCR: data_o = fill_a_i + offs_trunc_s;
            default:   data_o = fill_a_i;
        endcase
    end

endmodule

// File: rtl/mem_fill.sv
// Board-state RAM fill sequencer: writes a constant/checker/incrementing pattern
// over an inclusive wrap-around address range, then optionally reads it back.
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2,
    parameter int COL_W  = 3,
    parameter int RD_LAT = 0
) (
    input logic     clk,
    input logic     rst,
    mem_fill_if.slave bus
);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(32'd1);
    localparam logic [ADDR_W:0]   ERR_MAX  = (ADDR_W+1)'(depth_of(ADDR_W));
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);
    localparam bit                LAT0     = (RD_LAT == 0);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_a_q, fill_a_d;
    logic [DATA_W-1:0] fill_b_q, fill_b_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic              verify_q, verify_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] rd_dly_q, rd_dly_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [ADDR_W:0]   err_q, err_d;

    logic              idle_s;
    logic [1:0]        pat_mode_s;
    logic [DATA_W-1:0] pat_a_s;
    logic [DATA_W-1:0] pat_b_s;
    logic [ADDR_W-1:0] pat_start_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [ADDR_W-1:0] exp_addr_s;
    logic [DATA_W-1:0] exp_data_s;
    logic              cmp_en_s;
    logic              abort_hit_s;

    // The first write is prepared on the start edge itself, before the request
    // fields are latched, so the write-side pattern looks at the live inputs in IDLE.
    assign idle_s      = (state_q == ST_IDLE);
    assign pat_mode_s  = idle_s ? bus.mode       : mode_q;
    assign pat_a_s     = idle_s ? bus.fill_a     : fill_a_q;
    assign pat_b_s     = idle_s ? bus.fill_b     : fill_b_q;
    assign pat_start_s = idle_s ? bus.start_addr : start_q;
    assign wr_addr_s   = idle_s ? bus.start_addr : (ram_addr_q + ADDR_ONE);

    // A registered RAM returns data one cycle late, so compare against the
    // address presented in the previous cycle.
    assign exp_addr_s  = LAT0 ? rd_addr_q : rd_dly_q;
    assign cmp_en_s    = LAT0 ? (state_q == ST_VERIFY)
                              : (cmp_vld_q && ((state_q == ST_VERIFY) || (state_q == ST_DRAIN)));
    assign abort_hit_s = bus.abort &&
                         ((state_q == ST_FILL) || (state_q == ST_VERIFY) || (state_q == ST_DRAIN));

    mem_fill_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COL_W(COL_W)) u_wr_pat (
        .addr_i       (wr_addr_s),
        .start_addr_i (pat_start_s),
        .mode_i       (pat_mode_s),
        .fill_a_i     (pat_a_s),
        .fill_b_i     (pat_b_s),
        .data_o       (wr_data_s)
    );

    mem_fill_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COL_W(COL_W)) u_exp_pat (
        .addr_i       (exp_addr_s),
        .start_addr_i (start_q),
        .mode_i       (mode_q),
        .fill_a_i     (fill_a_q),
        .fill_b_i     (fill_b_q),
        .data_o       (exp_data_s)
    );

    // Next-state and registered-output logic for the fill/verify sequence.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        fill_a_d   = fill_a_q;
        fill_b_d   = fill_b_q;
        start_d    = start_q;
        verify_d   = verify_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        rd_addr_d  = rd_addr_q;
        rd_dly_d   = rd_addr_q;
        cmp_vld_d  = (state_q == ST_VERIFY);
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        if (cmp_en_s && (bus.rd_data != exp_data_s) && (err_q != ERR_MAX)) begin
            err_d = err_q + CNT_ONE;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d     = bus.mode;
                    fill_a_d   = bus.fill_a;
                    fill_b_d   = bus.fill_b;
                    start_d    = bus.start_addr;
                    verify_d   = bus.verify_en;
                    len_d      = {1'b0, bus.end_addr - bus.start_addr} + CNT_ONE;
                    cnt_d      = CNT_ONE;
                    ram_we_d   = 1'b1;
                    ram_addr_d = wr_addr_s;
                    ram_data_d = wr_data_s;
                    busy_d     = 1'b1;
                    err_d      = '0;
                    state_d    = ST_FILL;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (cnt_q == len_q) begin
                    cnt_d = CNT_ONE;
                    if (verify_q) begin
                        rd_addr_d = start_q;
                        state_d   = ST_VERIFY;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                    ram_we_d   = 1'b1;
                    ram_addr_d = wr_addr_s;
                    ram_data_d = wr_data_s;
                end
            end
            ST_VERIFY: begin
                if (cnt_q == len_q) begin
                    if (LAT0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit_s) begin
            ram_we_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            aborted_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'b00;
            fill_a_q   <= '0;
            fill_b_q   <= '0;
            start_q    <= '0;
            verify_q   <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            rd_addr_q  <= '0;
            rd_dly_q   <= '0;
            cmp_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            fill_a_q   <= fill_a_d;
            fill_b_q   <= fill_b_d;
            start_q    <= start_d;
            verify_q   <= verify_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_dly_q   <= rd_dly_d;
            cmp_vld_q  <= cmp_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_mem_fill.sv
// Scoreboard bench for mem_fill: two instances (combinational and registered RAM
// read) share one stimulus stream; a monitor matches every write and done/abort pulse.
module tb_mem_fill;
    import mem_fill_pkg::*;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int kind; int cyc; int err; } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;

    logic       start_s, abort_s, ver_s, force_zero;
    logic [1:0] mode_s, fill_a_s, fill_b_s;
    logic [5:0] sa_s, ea_s;

    logic [1:0] mem0 [64];
    logic [1:0] mem1 [64];
    logic [1:0] snap [64];
    logic [1:0] rd1_q;

    wr_t wr0_q[$], wr1_q[$];
    ev_t ev0_q[$], ev1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_fill_if #(.ADDR_W(6), .DATA_W(2)) if0 ();
    mem_fill_if #(.ADDR_W(6), .DATA_W(2)) if1 ();

    assign if0.start = start_s;   assign if1.start = start_s;
    assign if0.abort = abort_s;   assign if1.abort = abort_s;
    assign if0.mode = mode_s;     assign if1.mode = mode_s;
    assign if0.fill_a = fill_a_s; assign if1.fill_a = fill_a_s;
    assign if0.fill_b = fill_b_s; assign if1.fill_b = fill_b_s;
    assign if0.start_addr = sa_s; assign if1.start_addr = sa_s;
    assign if0.end_addr = ea_s;   assign if1.end_addr = ea_s;
    assign if0.verify_en = ver_s; assign if1.verify_en = ver_s;
    assign if0.rd_data = force_zero ? 2'b00 : mem0[if0.rd_addr];
    assign if1.rd_data = force_zero ? 2'b00 : rd1_q;

    mem_fill #(.ADDR_W(6), .DATA_W(2), .COL_W(3), .RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mem_fill #(.ADDR_W(6), .DATA_W(2), .COL_W(3), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // RAM models: dut0 reads combinationally, dut1 through a one-cycle register
    always @(posedge clk) begin
        if (if0.ram_we) mem0[if0.ram_addr] <= if0.ram_data;
        if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_data;
        rd1_q <= mem1[if1.rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int a, input int d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        wr0_q.push_back(w);
        wr1_q.push_back(w);
    endtask

    task automatic push_ev(input int dut, input int kind, input int c, input int err);
        ev_t e;
        e.kind = kind; e.cyc = c; e.err = err;
        if (dut == 0) ev0_q.push_back(e); else ev1_q.push_back(e);
    endtask

    task automatic mon(input int d, input logic we, input logic [5:0] addr, input logic [1:0] data,
                       input logic dn, input logic ab, input logic bsy, input logic [6:0] err);
        wr_t w;
        ev_t e;
        int  kind;
        if (we) begin
            if ((d == 0 && wr0_q.size() == 0) || (d == 1 && wr1_q.size() == 0)) begin
                chk($sformatf("dut%0d unexpected_write_addr", d), int'(addr), -1);
            end else begin
                if (d == 0) w = wr0_q.pop_front(); else w = wr1_q.pop_front();
                chk($sformatf("dut%0d wr_addr", d), int'(addr), w.addr);
                chk($sformatf("dut%0d wr_data@%0d", d, w.addr), int'(data), w.data);
                chk($sformatf("dut%0d wr_cycle@%0d", d, w.addr), cyc, w.cyc);
            end
        end
        if (dn || ab) begin
            kind = dn ? (ab ? 3 : 1) : 2;
            if ((d == 0 && ev0_q.size() == 0) || (d == 1 && ev1_q.size() == 0)) begin
                chk($sformatf("dut%0d unexpected_event", d), kind, 0);
            end else begin
                if (d == 0) e = ev0_q.pop_front(); else e = ev1_q.pop_front();
                chk($sformatf("dut%0d ev_kind", d), kind, e.kind);
                chk($sformatf("dut%0d ev_cycle", d), cyc, e.cyc);
                chk($sformatf("dut%0d ev_err_count", d), int'(err), e.err);
                chk($sformatf("dut%0d ev_busy", d), int'(bsy), 0);
            end
        end
    endtask

    // Monitor: sample registered outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        mon(0, if0.ram_we, if0.ram_addr, if0.ram_data, if0.done, if0.aborted, if0.busy, if0.err_count);
        mon(1, if1.ram_we, if1.ram_addr, if1.ram_data, if1.done, if1.aborted, if1.busy, if1.err_count);
    end

    task automatic wait_empty(input string name, input int budget);
        int t = 0;
        while (t < budget && (wr0_q.size() + wr1_q.size() + ev0_q.size() + ev1_q.size()) != 0) begin
            @(negedge clk);
            t++;
        end
        chk({name, " pending"}, wr0_q.size() + wr1_q.size() + ev0_q.size() + ev1_q.size(), 0);
        wr0_q.delete(); wr1_q.delete(); ev0_q.delete(); ev1_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Called at a falling edge; t0 must already hold the current cycle.
    task automatic launch(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b,
                          input logic [5:0] sa, input logic [5:0] ea, input logic v, input logic ab);
        mode_s = m; fill_a_s = a; fill_b_s = b; sa_s = sa; ea_s = ea; ver_s = v;
        start_s = 1'b1; abort_s = ab;
        @(negedge clk);
        start_s = 1'b0; abort_s = 1'b0;
        mode_s = ~m; fill_a_s = ~a; fill_b_s = ~b; sa_s = sa + 6'd7; ea_s = ea + 6'd3; ver_s = ~v;
    endtask

    function automatic int outs(input int d);
        if (d == 0)
            return int'({if0.ram_we, if0.ram_addr, if0.ram_data, if0.rd_addr, if0.busy, if0.done, if0.aborted, if0.err_count});
        else
            return int'({if1.ram_we, if1.ram_addr, if1.ram_data, if1.rd_addr, if1.busy, if1.done, if1.aborted, if1.err_count});
    endfunction

    function automatic int chk_pat(input int a);
        return ((a & 1) ^ ((a >> 3) & 1)) != 0 ? 2 : 1;
    endfunction

    initial begin
        int bad;
        rst = 1'b1; start_s = 1'b0; abort_s = 1'b0; ver_s = 1'b0; force_zero = 1'b0;
        mode_s = 2'b00; fill_a_s = 2'b00; fill_b_s = 2'b00; sa_s = 6'd0; ea_s = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs dut0", outs(0), 0);
        chk("reset_outputs dut1", outs(1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Preload every cell with 3 so the following clear is observable
        t0 = cyc;
        for (int a = 0; a < 64; a++) push_wr(a, 3, t0 + 1 + a);
        push_ev(0, 1, t0 + 65, 0); push_ev(1, 1, t0 + 65, 0);
        launch(2'b00, 2'd3, 2'd0, 6'd0, 6'd63, 1'b0, 1'b0);
        wait_empty("preload", 200);

        // Full clear
        t0 = cyc;
        for (int a = 0; a < 64; a++) push_wr(a, 0, t0 + 1 + a);
        push_ev(0, 1, t0 + 65, 0); push_ev(1, 1, t0 + 65, 0);
        launch(2'b00, 2'd0, 2'd0, 6'd0, 6'd63, 1'b0, 1'b0);
        wait_empty("full_clear", 200);
        bad = 0;
        for (int a = 0; a < 64; a++) if (mem0[a] != 2'd0 || mem1[a] != 2'd0) bad++;
        chk("full_clear nonzero_cells", bad, 0);

        // Single cell with forced read-back errors
        force_zero = 1'b1;
        t0 = cyc;
        push_wr(5, 3, t0 + 1);
        push_ev(0, 1, t0 + 3, 1); push_ev(1, 1, t0 + 4, 1);
        launch(2'b00, 2'd3, 2'd0, 6'd5, 6'd5, 1'b1, 1'b0);
        wait_empty("single_cell", 40);
        force_zero = 1'b0;

        // Checkerboard with verify; err_count must restart from 0
        t0 = cyc;
        for (int a = 0; a < 64; a++) push_wr(a, chk_pat(a), t0 + 1 + a);
        push_ev(0, 1, t0 + 129, 0); push_ev(1, 1, t0 + 130, 0);
        launch(2'b01, 2'd1, 2'd2, 6'd0, 6'd63, 1'b1, 1'b0);
        wait_empty("checker", 300);
        chk("checker cell0", int'(mem0[0]), 1);
        chk("checker cell1", int'(mem0[1]), 2);
        chk("checker cell8", int'(mem0[8]), 2);
        chk("checker cell9", int'(mem0[9]), 1);
        for (int a = 0; a < 64; a++) snap[a] = mem0[a];

        // Wrap-around incrementing fill
        t0 = cyc;
        push_wr(62, 0, t0 + 1); push_wr(63, 1, t0 + 2); push_wr(0, 2, t0 + 3); push_wr(1, 3, t0 + 4);
        push_ev(0, 1, t0 + 5, 0); push_ev(1, 1, t0 + 5, 0);
        launch(2'b10, 2'd0, 2'd0, 6'd62, 6'd1, 1'b0, 1'b0);
        wait_empty("wrap_incr", 40);
        bad = 0;
        for (int a = 2; a < 62; a++) if (mem0[a] != snap[a]) bad++;
        chk("wrap_incr untouched_changed", bad, 0);
        chk("wrap_incr cell0", int'(mem0[0]), 2);

        // Abort during write cycle 10
        t0 = cyc;
        for (int a = 0; a < 10; a++) push_wr(a, 2, t0 + 1 + a);
        push_ev(0, 2, t0 + 11, 0); push_ev(1, 2, t0 + 11, 0);
        launch(2'b00, 2'd2, 2'd0, 6'd0, 6'd63, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        wait_empty("abort", 40);
        repeat (20) @(negedge clk);
        chk("abort busy dut0", int'(if0.busy), 0);

        // Start and abort together in IDLE: start wins
        t0 = cyc;
        for (int a = 0; a < 4; a++) push_wr(a, 1, t0 + 1 + a);
        push_ev(0, 1, t0 + 5, 0); push_ev(1, 1, t0 + 5, 0);
        launch(2'b00, 2'd1, 2'd0, 6'd0, 6'd3, 1'b0, 1'b1);
        wait_empty("start_with_abort", 40);

        // Reset in the middle of a verify pass that is accumulating errors
        force_zero = 1'b1;
        t0 = cyc;
        for (int a = 0; a < 64; a++) push_wr(a, chk_pat(a), t0 + 1 + a);
        launch(2'b01, 2'd1, 2'd2, 6'd0, 6'd63, 1'b1, 1'b0);
        repeat (73) @(negedge clk);
        chk("mid_verify err dut0", int'(if0.err_count), 9);
        chk("mid_verify err dut1", int'(if1.err_count), 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_zero = 1'b0;
        chk("mid_reset outputs dut0", outs(0), 0);
        chk("mid_reset outputs dut1", outs(1), 0);
        wait_empty("mid_reset", 10);

        // Normal verified operation after the reset
        t0 = cyc;
        push_wr(10, 2, t0 + 1); push_wr(11, 2, t0 + 2); push_wr(12, 2, t0 + 3);
        push_ev(0, 1, t0 + 7, 0); push_ev(1, 1, t0 + 8, 0);
        launch(2'b00, 2'd2, 2'd0, 6'd10, 6'd12, 1'b1, 1'b0);
        wait_empty("post_reset", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_fill.md
Name: mem_fill

Overview:
Parametrised successor to mem_reset. Sequences a single-port write stream into a board-state RAM such as checkerboard_state_ram. It fills an inclusive, wrap-around address range with a constant, checkerboard or incrementing pattern. An optional read-back verify pass counts mismatches. Sits between the game controller and the state RAM write mux; the controller owns the mux select while busy=1.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W
DATA_W, 2, RAM data width
COL_W, 3, log2 of board row length; used for checkerboard parity (8x8 board by default)
RD_LAT, 0, RAM read latency in cycles; legal values 0 (combinational) or 1 (registered)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  cancel current operation
mode  in  2  00 CONST, 01 CHECKER, 10 INCR, 11 reserved (behaves as CONST)
fill_a  in  DATA_W  primary fill value
fill_b  in  DATA_W  alternate value (CHECKER odd cells)
start_addr  in  ADDR_W  first address, inclusive
end_addr  in  ADDR_W  last address, inclusive
verify_en  in  1  run read-back pass after fill
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM write address
ram_data  out  DATA_W  RAM write data
rd_addr  out  ADDR_W  RAM read address (verify pass)
rd_data  in  DATA_W  RAM read data
busy  out  1  high from the cycle after start until done/aborted
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
err_count  out  ADDR_W+1  verify mismatches; held until next start

Behaviour:
- Reset: state IDLE. ram_we, ram_addr, ram_data, rd_addr, busy, done, aborted and err_count are all 0. Reset overrides every state, including mid-fill.
- All outputs are registered.
- On start, latch mode, fill_a, fill_b, start_addr, end_addr and verify_en. Later changes to these inputs have no effect on the running operation.
- States: IDLE, FILL, VERIFY, DRAIN, FINISH.
- IDLE:
  - start=1 -> FILL; clear err_count.
  - start while busy is ignored.
- Range length N = ((end_addr - start_addr) mod DEPTH) + 1, so 1 <= N <= DEPTH.
  - start_addr > end_addr wraps through DEPTH-1 to 0.
  - start_addr == end_addr writes exactly 1 cell.
  - The walk counter is ADDR_W+1 bits wide so that N = DEPTH is representable.
- FILL: write cycles 1..N after the start cycle, with ram_we=1 and ram_addr stepping +1 mod DEPTH.
  - After the last write: verify=1 -> VERIFY, else -> FINISH.
  - ram_we=0 in every non-FILL cycle.
- Pattern, with offset k = (addr - start_addr) mod DEPTH:
  - CONST: data = fill_a.
  - CHECKER: data = fill_a when addr[0] ^ addr[COL_W] == 0, else fill_b.
  - INCR: data = fill_a + k, truncated to DATA_W.
- VERIFY: rd_addr walks the same N addresses, one per cycle.
  - Expected data comes from the same pattern function.
  - RD_LAT=0: compare rd_data in the same cycle.
  - RD_LAT=1: compare one cycle later, using the delayed address/offset; DRAIN covers the last compare.
  - Each mismatch increments err_count, saturating at DEPTH.
- FINISH: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- Done timing: cycle N+1 without verify; 2N+1 with RD_LAT=0; 2N+2 with RD_LAT=1.
- abort in any non-IDLE state:
  - Next cycle: IDLE, ram_we=0, aborted=1 for one cycle, busy=0, no done.
  - Writes already issued stand; err_count holds its partial value.
  - abort together with start in IDLE: start wins, abort ignored.
- A write and an abort in the same cycle: that write is still issued; abort takes effect on the next edge.

Decomposition:
- Package mem_fill_pkg:
  - mode encodings MODE_CONST/MODE_CHECKER/MODE_INCR
  - state enum
  - helper constant DEPTH derivation
- Sub-module mem_fill_pattern: combinational (addr, start_addr, mode, fill_a, fill_b) -> data. Instantiated twice, once for the write path and once for the verify expected value.

Test Plan:
- Full clear: start_addr=0, end_addr=63, CONST, fill_a=0, no verify. Expect 64 writes in cycles 1..64, done in cycle 65, all 64 cells read 0.
- Checkerboard with verify: start_addr=0, end_addr=63, CHECKER, fill_a=1, fill_b=2, verify_en=1, RD_LAT=0. Expect cell 0=1, cell 1=2, cell 8=2, cell 9=1; err_count=0; done in cycle 129.
- Wrap and INCR: start_addr=62, end_addr=1, INCR, fill_a=0. Expect exactly 4 writes: addr 62=0, 63=1, 0=2, 1=3. Addresses 2..61 untouched.
- Single cell plus error injection: start_addr=end_addr=5, CONST, fill_a=3, verify_en=1. Bench forces rd_data=0 during verify. Expect err_count=1 and one done pulse.
- Abort: abort asserted at write cycle 10 of a full fill. Expect aborted pulse the next cycle, busy=0, no done, no further writes; a new start is then accepted normally.
- Reset mid-verify with RD_LAT=1: assert rst. Expect all outputs 0 on the next edge; a following start gives err_count cleared and correct done timing.
